// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, square/piece types, controller state enum
// and the starting-position lookup used by board_state_ctrl.
package chess_pkg;

    localparam int PC_W = 4;

    typedef logic [5:0]      square_t;
    typedef logic [PC_W-1:0] piece_t;

    localparam piece_t W_ROOK   = 4'd0;
    localparam piece_t W_KNIGHT = 4'd1;
    localparam piece_t W_BISHOP = 4'd2;
    localparam piece_t W_QUEEN  = 4'd3;
    localparam piece_t W_KING   = 4'd4;
    localparam piece_t W_PAWN   = 4'd5;
    localparam piece_t B_ROOK   = 4'd6;
    localparam piece_t B_KNIGHT = 4'd7;
    localparam piece_t B_BISHOP = 4'd8;
    localparam piece_t B_QUEEN  = 4'd9;
    localparam piece_t B_KING   = 4'd10;
    localparam piece_t B_PAWN   = 4'd11;
    localparam piece_t PC_EMPTY = 4'd15;

    // Black codes are the white codes offset by this amount.
    localparam piece_t BLACK_OFFSET = B_ROOK - W_ROOK;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT_VB,
        ST_CHECK,
        ST_COMMIT
    } board_state_e;

    function automatic piece_t start_piece(input square_t sq);
        piece_t back;
        piece_t res;
        case (sq[2:0])
            3'd0, 3'd7: back = W_ROOK;
            3'd1, 3'd6: back = W_KNIGHT;
            3'd2, 3'd5: back = W_BISHOP;
            3'd3:       back = W_QUEEN;
            default:    back = W_KING;
        endcase
        case (sq[5:3])
            3'd0:    res = back;
            3'd1:    res = W_PAWN;
            3'd6:    res = B_PAWN;
            3'd7:    res = back + BLACK_OFFSET;
            default: res = PC_EMPTY;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/board_state_ctrl.sv
// Live 8x8 piece map with start-position load, frame-synchronous move commits and a
// registered renderer read port. Optional macro: BOARD_STATE_CTRL_VBLANK_SYNC_EN.
module board_state_ctrl
    import chess_pkg::*;
#(
    parameter int          PIECE_W    = 4,
    parameter int unsigned EMPTY_CODE = 15
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               init_req,
    input  logic               mv_valid,
    output logic               mv_ready,
    input  logic [5:0]         mv_from,
    input  logic [5:0]         mv_to,
    output logic               mv_done,
    output logic               mv_err,
    output logic               cap_valid,
    output logic [PIECE_W-1:0] cap_piece,
    output logic               busy,
    input  logic [2:0]         rd_row,
    input  logic [2:0]         rd_col,
    output logic [PIECE_W-1:0] rd_piece
);

    localparam logic [PIECE_W-1:0] EMPTY_P = PIECE_W'(EMPTY_CODE);

    board_state_e       state_q, state_d;
    square_t            init_cnt_q, init_cnt_d;
    square_t            from_q, from_d;
    square_t            to_q, to_d;
    logic [PIECE_W-1:0] src_q, src_d;
    logic [PIECE_W-1:0] dst_q, dst_d;
    logic               mv_done_q, mv_done_d;
    logic               mv_err_q, mv_err_d;
    logic               cap_valid_q, cap_valid_d;
    logic [PIECE_W-1:0] cap_piece_q, cap_piece_d;
    logic [PIECE_W-1:0] rd_piece_q, rd_piece_d;
    logic [PIECE_W-1:0] map_q [64];
    logic [PIECE_W-1:0] map_d [64];

    logic               init_we;
    logic               commit_we;
    piece_t             start_code;
    logic [PIECE_W-1:0] init_piece;

`ifndef BOARD_STATE_CTRL_VBLANK_SYNC_EN
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    // The start table uses the package empty code; remap it to this instance's code.
    assign start_code = start_piece(init_cnt_q);
    assign init_piece = (start_code == PC_EMPTY) ? EMPTY_P : PIECE_W'(start_code);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        from_d      = from_q;
        to_d        = to_q;
        src_d       = src_q;
        dst_d       = dst_q;
        mv_done_d   = 1'b0;
        mv_err_d    = 1'b0;
        cap_valid_d = 1'b0;
        cap_piece_d = cap_piece_q;
        init_we     = 1'b0;
        commit_we   = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we    = 1'b1;
                init_cnt_d = init_cnt_q + 6'd1;
                if (init_cnt_q == 6'd63) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end else if (mv_valid) begin
                    from_d = mv_from;
                    to_d   = mv_to;
`ifdef BOARD_STATE_CTRL_VBLANK_SYNC_EN
                    state_d = ST_WAIT_VB;
`else
                    state_d = ST_CHECK;
`endif
                end
            end
            ST_WAIT_VB: begin
`ifdef BOARD_STATE_CTRL_VBLANK_SYNC_EN
                if (frame_start) begin
                    state_d = ST_CHECK;
                end
`else
                state_d = ST_CHECK;
`endif
            end
            ST_CHECK: begin
                if ((from_q == to_q) || (map_q[from_q] == EMPTY_P)) begin
                    mv_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    src_d   = map_q[from_q];
                    dst_d   = map_q[to_q];
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit_we = 1'b1;
                mv_done_d = 1'b1;
                if (dst_q != EMPTY_P) begin
                    cap_valid_d = 1'b1;
                    cap_piece_d = dst_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // A reset landing on the commit edge discards the move; the map is reloaded anyway.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            map_d[i] = map_q[i];
            if (init_we && (init_cnt_q == square_t'(i))) begin
                map_d[i] = init_piece;
            end
            if (commit_we && !reset) begin
                if (from_q == square_t'(i)) begin
                    map_d[i] = EMPTY_P;
                end
                if (to_q == square_t'(i)) begin
                    map_d[i] = src_q;
                end
            end
        end
    end

    assign rd_piece_d = (state_q == ST_INIT) ? EMPTY_P : map_q[{rd_row, rd_col}];

    always_ff @(posedge vga_clk) begin
        map_q <= map_d;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            from_q      <= '0;
            to_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            mv_done_q   <= 1'b0;
            mv_err_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_piece_q <= '0;
            rd_piece_q  <= EMPTY_P;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            from_q      <= from_d;
            to_q        <= to_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            mv_done_q   <= mv_done_d;
            mv_err_q    <= mv_err_d;
            cap_valid_q <= cap_valid_d;
            cap_piece_q <= cap_piece_d;
            rd_piece_q  <= rd_piece_d;
        end
    end

    assign mv_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mv_done   = mv_done_q;
    assign mv_err    = mv_err_q;
    assign cap_valid = cap_valid_q;
    assign cap_piece = cap_piece_q;
    assign rd_piece  = rd_piece_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Scoreboard bench for board_state_ctrl: random and directed moves against a board-level
// reference model; a separate monitor checks every done/err pulse against the queue.
module tb_board_state_ctrl;

    localparam int PW  = 4;
    localparam int EMP = 15;

    logic          vga_clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          init_req = 1'b0;
    logic          mv_valid = 1'b0;
    logic [5:0]    mv_from = '0;
    logic [5:0]    mv_to = '0;
    logic [2:0]    rd_row = '0;
    logic [2:0]    rd_col = '0;
    logic          mv_ready, mv_done, mv_err, cap_valid, busy;
    logic [PW-1:0] cap_piece, rd_piece;

    board_state_ctrl #(.PIECE_W(PW), .EMPTY_CODE(EMP)) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .init_req    (init_req),
        .mv_valid    (mv_valid),
        .mv_ready    (mv_ready),
        .mv_from     (mv_from),
        .mv_to       (mv_to),
        .mv_done     (mv_done),
        .mv_err      (mv_err),
        .cap_valid   (cap_valid),
        .cap_piece   (cap_piece),
        .busy        (busy),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_piece    (rd_piece)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        bit cap;
        int cap_p;
        int at_cyc;
        int from;
        int to;
    } exp_t;

    exp_t q[$];
    int   model[64];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference start position, written row by row as the board is laid out.
    function automatic void model_start();
        int white_back[8] = '{0, 1, 2, 3, 4, 2, 1, 0};
        int black_back[8] = '{6, 7, 8, 9, 10, 8, 7, 6};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (r)
                    0:       model[r*8+c] = white_back[c];
                    1:       model[r*8+c] = 5;
                    6:       model[r*8+c] = 11;
                    7:       model[r*8+c] = black_back[c];
                    default: model[r*8+c] = EMP;
                endcase
            end
        end
    endfunction

    // Monitor: every done/err pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            if (cap_valid && !mv_done) check("cap_without_done", 1, 0);
            if (mv_done || mv_err) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("err_pulse", int'(mv_err), int'(e.is_err));
                    check("done_pulse", int'(mv_done), int'(!e.is_err));
                    check("pulse_cycle", cyc, e.at_cyc);
                    if (!e.is_err) begin
                        check("cap_valid", int'(cap_valid), int'(e.cap));
                        if (e.cap) check("cap_piece", int'(cap_piece), e.cap_p);
                    end
                    $display("move %0d->%0d: %s cap=%0b piece=%0d at cycle %0d",
                             e.from, e.to, mv_err ? "err" : "done", cap_valid, cap_piece, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge vga_clk);
    endtask

    // Called at the negedge just after the edge that entered INIT.
    task automatic init_window(input string tag);
        for (int j = 0; j < 64; j++) begin
            check({tag, "_busy"}, int'(busy), 1);
            check({tag, "_ready"}, int'(mv_ready), 0);
            if (j > 0) check({tag, "_rd_empty"}, int'(rd_piece), EMP);
            rd_row = 3'($urandom_range(0, 7));
            rd_col = 3'($urandom_range(0, 7));
            tick();
        end
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_ready_end"}, int'(mv_ready), 1);
        $display("init window %s complete at cycle %0d", tag, cyc);
    endtask

    task automatic read_board(input string tag);
        for (int sq = 0; sq < 64; sq++) begin
            rd_row = 3'(sq / 8);
            rd_col = 3'(sq % 8);
            tick();
            check({tag, "_rd_sq"}, int'(rd_piece), model[sq]);
        end
        $display("board readback %s at cycle %0d", tag, cyc);
    endtask

    // d = cycles from acceptance to the strobe edge; d == 0 drives no strobe at all.
    task automatic do_move(input int from, input int to, input int d, input bit fs_at_accept);
        int   n = 0;
        int   acc;
        exp_t e;
        mv_from  = 6'(from);
        mv_to    = 6'(to);
        mv_valid = 1'b1;
        while (!mv_ready && n < 200) begin
            tick();
            n++;
        end
        if (!mv_ready) begin
            check("ready_timeout", 0, 1);
            mv_valid = 1'b0;
            return;
        end
        acc      = cyc + 1;
        e.from   = from;
        e.to     = to;
        e.is_err = (from == to) || (model[from] == EMP);
        e.cap    = !e.is_err && (model[to] != EMP);
        e.cap_p  = model[to];
`ifdef BOARD_STATE_CTRL_VBLANK_SYNC_EN
        e.at_cyc = acc + d + (e.is_err ? 1 : 2);
`else
        e.at_cyc = acc + (e.is_err ? 1 : 2);
`endif
        q.push_back(e);
        if (!e.is_err) begin
            model[to]   = model[from];
            model[from] = EMP;
        end
        frame_start = fs_at_accept;
        tick();
        mv_valid    = 1'b0;
        frame_start = 1'b0;
        check("ready_after_accept", int'(mv_ready), 0);
        if (d > 0) begin
            repeat (d - 1) tick();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            check("pulse_timeout", int'(q.size()), 0);
            q.delete();
        end
    endtask

    task automatic read_sq(input int sq);
        rd_row = 3'(sq / 8);
        rd_col = 3'(sq % 8);
        tick();
        check("rd_one", int'(rd_piece), model[sq]);
    endtask

    initial begin
        int occ[$];
        int from;
        int n;
        model_start();

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_ready", int'(mv_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(mv_done), 0);
        check("rst_err", int'(mv_err), 0);
        check("rst_cap_valid", int'(cap_valid), 0);
        check("rst_cap_piece", int'(cap_piece), 0);
        check("rst_rd_piece", int'(rd_piece), EMP);
        reset = 1'b0;
        init_window("power_up");
        read_board("start");

        // Directed moves from the start position.
        do_move(52, 36, 10, 1'b0);
        read_sq(36);
        read_sq(52);
        do_move(36, 12, 3, 1'b1);
        read_sq(12);
        read_sq(36);
        do_move(20, 28, 2, 1'b0);
        do_move(5, 5, 1, 1'b0);
`ifndef BOARD_STATE_CTRL_VBLANK_SYNC_EN
        do_move(11, 27, 0, 1'b0);
`endif
        read_board("directed");

        // init_req beats a simultaneous move request.
        init_req = 1'b1;
        mv_valid = 1'b1;
        mv_from  = 6'd8;
        mv_to    = 6'd24;
        tick();
        init_req = 1'b0;
        mv_valid = 1'b0;
        model_start();
        init_window("init_req");
        read_board("after_init_req");

        // Random moves, biased towards occupied sources.
        for (int k = 0; k < 40; k++) begin
            occ.delete();
            for (int s = 0; s < 64; s++) if (model[s] != EMP) occ.push_back(s);
            if ($urandom_range(0, 9) < 7 && occ.size() > 0)
                from = occ[$urandom_range(0, occ.size() - 1)];
            else
                from = $urandom_range(0, 63);
            do_move(from, $urandom_range(0, 63), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
            if (k % 10 == 9) read_board("random");
        end

        // Reset while a move is in flight: discarded silently, map reloaded.
        mv_from  = 6'd49;
        mv_to    = 6'd33;
        mv_valid = 1'b1;
        n = 0;
        while (!mv_ready && n < 200) begin
            tick();
            n++;
        end
        check("ready_before_reset", int'(mv_ready), 1);
        tick();
        mv_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        model_start();
        init_window("mid_move_reset");
        read_board("after_reset");

        do_move(1, 18, 2, 1'b0);
        do_move(18, 1, 4, 1'b1);
        read_board("final");

        repeat (5) tick();
        check("queue_empty", int'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
